// File: rtl/jb_power_down_mc_if.sv
// Bus bundle for jb_power_down_mc: alarm/enable inputs, clear request and
// the shutdown, status and first-fault outputs.
interface jb_power_down_mc_if #(
    parameter int unsigned NUM_CH = 4
) ();
    localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] psu_alarm_n;
    logic [NUM_CH-1:0] psu_alarm_enable;
    logic              clear_req;
    logic              psu_shutdown;
    logic              pa_shutdown;
    logic              dac_shutdown;
    logic              clear_reject;
    logic [NUM_CH-1:0] alarm_status;
    logic [ChW-1:0]    first_alarm_ch;
    logic              first_alarm_valid;
    logic [1:0]        fsm_state;

    modport master (
        output psu_alarm_n, psu_alarm_enable, clear_req,
        input  psu_shutdown, pa_shutdown, dac_shutdown, clear_reject,
        input  alarm_status, first_alarm_ch, first_alarm_valid, fsm_state
    );

    modport slave (
        input  psu_alarm_n, psu_alarm_enable, clear_req,
        output psu_shutdown, pa_shutdown, dac_shutdown, clear_reject,
        output alarm_status, first_alarm_ch, first_alarm_valid, fsm_state
    );
endinterface

// File: rtl/jb_power_down_mc.sv
// Multi-channel PSU-alarm power-down controller. Alarms are synchronised,
// deglitched and, when enabled, latch a shutdown that turns PA off first and
// the DAC after DAC_DELAY; a clear releases them in reverse order.
// Optional macro JB_PD_AUTO_RECOVER_EN: leave SHUTDOWN automatically after
// RECOVER_CYCLES alarm-free cycles (status and first-fault are kept).
module jb_power_down_mc #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DEGLITCH_CYCLES = 8,
    parameter int unsigned DAC_DELAY       = 16,
    parameter int unsigned RELEASE_DELAY   = 16,
    parameter int unsigned RECOVER_CYCLES  = 1024
) (
    input  logic                axi_clk,
    input  logic                axi_resetn,
    jb_power_down_mc_if.slave   bus
);
    localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CntW = $clog2(DEGLITCH_CYCLES + 1);

    if (NUM_CH < 1 || NUM_CH > 16 || DEGLITCH_CYCLES < 1 || DEGLITCH_CYCLES > 255 ||
        DAC_DELAY < 1 || DAC_DELAY > 65535 || RELEASE_DELAY < 1 ||
        RELEASE_DELAY > 65535 || RECOVER_CYCLES < 1) begin : g_param_check
        $error("jb_power_down_mc: parameter out of range");
    end

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPaOff    = 2'd1,
        StShutdown = 2'd2,
        StRelease  = 2'd3
    } state_e;

    logic [NUM_CH-1:0] alarm_meta_q, alarm_sync_q, en_meta_q, en_sync_q;
    logic [CntW-1:0]   cnt_q [NUM_CH];
    logic [CntW-1:0]   cnt_d [NUM_CH];
    logic [NUM_CH-1:0] qual_q, qual_d, status_q, status_d, hit;
    logic [ChW-1:0]    first_ch_q, first_ch_d, first_idx;
    logic              first_valid_q, first_valid_d;
    state_e            state_q, state_d;
    logic [15:0]       dly_q, dly_d;
    logic              pa_q, pa_d, dac_q, dac_d, psu_q, psu_d, reject_q, reject_d;
    logic              trig, sw_clear, auto_clear;

    // Two-flop synchronisers; alarms idle high, enables idle low.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            alarm_meta_q <= '1;
            alarm_sync_q <= '1;
            en_meta_q    <= '0;
            en_sync_q    <= '0;
        end else begin
            alarm_meta_q <= bus.psu_alarm_n;
            alarm_sync_q <= alarm_meta_q;
            en_meta_q    <= bus.psu_alarm_enable;
            en_sync_q    <= en_meta_q;
        end
    end

    // Saturating low-sample counters; qualify once DEGLITCH_CYCLES lows are seen.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (alarm_sync_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CntW'(DEGLITCH_CYCLES)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            qual_d[i] = (cnt_q[i] == CntW'(DEGLITCH_CYCLES));
        end
    end

    assign hit  = qual_q & en_sync_q;
    assign trig = |hit;

    // Lowest-index enabled qualified channel.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) first_idx = ChW'(i);
        end
    end

`ifdef JB_PD_AUTO_RECOVER_EN
    localparam int unsigned RecW = $clog2(RECOVER_CYCLES + 1);
    logic [RecW-1:0] rec_q, rec_d;
    logic            alarm_free;

    assign alarm_free = &(alarm_sync_q | ~en_sync_q);
    assign auto_clear = (state_q == StShutdown) && alarm_free && !trig &&
                        (rec_q == RecW'(RECOVER_CYCLES));

    // Alarm-free run length while latched, saturating at RECOVER_CYCLES.
    always_comb begin
        rec_d = '0;
        if (state_q == StShutdown && alarm_free) begin
            rec_d = (rec_q == RecW'(RECOVER_CYCLES)) ? rec_q : rec_q + 1'b1;
        end
    end

    // Recovery counter register.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) rec_q <= '0;
        else             rec_q <= rec_d;
    end
`else
    assign auto_clear = 1'b0;
`endif

    assign sw_clear = (state_q == StShutdown) && bus.clear_req && !trig;

    // Shutdown sequencer: next state, delay counter and registered outputs.
    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        pa_d     = pa_q;
        dac_d    = dac_q;
        psu_d    = psu_q;
        reject_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    state_d = StPaOff;
                    pa_d    = 1'b1;
                    psu_d   = 1'b1;
                    dly_d   = '0;
                end
            end
            StPaOff: begin
                dly_d    = dly_q + 16'd1;
                reject_d = bus.clear_req;
                if (dly_q == 16'(DAC_DELAY - 1)) begin
                    state_d = StShutdown;
                    dac_d   = 1'b1;
                end
            end
            StShutdown: begin
                if (bus.clear_req && trig) begin
                    reject_d = 1'b1;
                end else if (sw_clear || auto_clear) begin
                    state_d = StRelease;
                    dac_d   = 1'b0;
                    psu_d   = 1'b0;
                    dly_d   = '0;
                end
            end
            StRelease: begin
                dly_d    = dly_q + 16'd1;
                reject_d = bus.clear_req;
                if (trig) begin
                    // Re-latch; PA never came back on.
                    state_d = StShutdown;
                    dac_d   = 1'b1;
                    psu_d   = 1'b1;
                end else if (dly_q == 16'(RELEASE_DELAY - 1)) begin
                    state_d = StIdle;
                    pa_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky status (set wins over clear) and first-fault capture.
    always_comb begin
        status_d      = (sw_clear ? '0 : status_q) | qual_q;
        first_ch_d    = first_ch_q;
        first_valid_d = first_valid_q;
        if (sw_clear) begin
            first_valid_d = 1'b0;
        end else if (!first_valid_q && trig) begin
            first_valid_d = 1'b1;
            first_ch_d    = first_idx;
        end
    end

    // State registers.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            qual_q        <= '0;
            status_q      <= '0;
            first_ch_q    <= '0;
            first_valid_q <= 1'b0;
            state_q       <= StIdle;
            dly_q         <= '0;
            pa_q          <= 1'b0;
            dac_q         <= 1'b0;
            psu_q         <= 1'b0;
            reject_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
            qual_q        <= qual_d;
            status_q      <= status_d;
            first_ch_q    <= first_ch_d;
            first_valid_q <= first_valid_d;
            state_q       <= state_d;
            dly_q         <= dly_d;
            pa_q          <= pa_d;
            dac_q         <= dac_d;
            psu_q         <= psu_d;
            reject_q      <= reject_d;
        end
    end

    assign bus.psu_shutdown      = psu_q;
    assign bus.pa_shutdown       = pa_q;
    assign bus.dac_shutdown      = dac_q;
    assign bus.clear_reject      = reject_q;
    assign bus.alarm_status      = status_q;
    assign bus.first_alarm_ch    = first_ch_q;
    assign bus.first_alarm_valid = first_valid_q;
    assign bus.fsm_state         = state_q;
endmodule
